alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
// - Initiator side of the 64-bit ALU op interface: accepts decoded RV64 instruction fields and operands.
// - Decodes them into the 4-bit ALU op, registers the operands and op, and drives the combinational ALU.
// - Captures alu_result/alu_zero, resolves branch outcome and returns a tagged response.
// - Sits between the ID stage and the ALU in the multi-cycle datapath.
// PARAMETERS
// - DATA_W  64  operand/result width
// - TAG_W   4   width of transaction tag passed through unchanged
// PORTS
// - clk          in   1       clock; all state updates on rising edge
// - rst          in   1       synchronous, active-high reset
// - req_valid    in   1       request present
// - req_ready    out  1       high only in IDLE
// - req_opcode   in   7       instr[6:0]
// - req_funct3   in   3       instr[14:12]
// - req_funct7   in   7       instr[31:25]
// - req_rs1      in   DATA_W  rs1 value
// - req_rs2      in   DATA_W  rs2 value
// - req_imm      in   DATA_W  pre-generated sign-extended immediate
// - req_tag      in   TAG_W   transaction tag
// - alu_a        out  DATA_W  ALU operand a (registered)
// - alu_b        out  DATA_W  ALU operand b (registered)
// - alu_op       out  4       ALU op (registered)
// - alu_result   in   DATA_W  ALU result (combinational from alu_a/b/op)
// - alu_zero     in   1       ALU zero flag
// - rsp_valid    out  1       response present
// - rsp_ready    in   1       consumer accepts response
// - rsp_result   out  DATA_W  captured ALU result; 0 when illegal
// - rsp_branch   out  1       instruction was a branch
// - rsp_taken    out  1       branch taken; 0 for non-branch
// - rsp_illegal  out  1       unsupported encoding
// - rsp_tag      out  TAG_W   echo of req_tag
// BEHAVIOUR
// - Reset: state=IDLE; every output 0, except req_ready=1.
// - ALU op codes: AND=0000, OR=0001, ADD=0010, SUB=0110, BLT=0111, SLL=1000, NOR=1100, NAND=1101.
// - Decode, with b=rs2 unless noted:
//   - opcode 0110011, f7=0000000: f3 000 ADD, 111 AND, 110 OR, 001 SLL.
//   - opcode 0110011, f7=0100000: f3 000 SUB.
//   - opcode 0010011: f3 000 ADD, b=imm; f3 001 with f7[6:1]=0 SLL, b=imm.
//   - opcode 0000011 (f3 011) and 0100011 (f3 011): ADD, b=imm.
//   - opcode 1100011: f3 000 BEQ / 001 BNE use SUB; f3 100 BLT / 101 BGE use BLT op.
//   - All other encodings are illegal. a=rs1 in every case.
// - Branch resolution (ALU BLT returns 0 when a<b signed):
//   - BEQ taken = zero; BNE taken = !zero; BLT taken = zero; BGE taken = !zero.
// - FSM IDLE -> EXEC -> RESP -> IDLE:
//   - IDLE: req_valid & req_ready at edge N latches a/b/op/tag/class; goes to EXEC (illegal: straight to RESP).
//   - EXEC (cycle N+1): alu_* stable; at end of cycle capture alu_result/alu_zero; go to RESP.
//   - RESP (from N+2): rsp_valid=1 and all rsp_* held stable until rsp_ready; on rsp_valid & rsp_ready go to IDLE.
//   - Latency: 2 cycles from accept to rsp_valid; 1 request per 3 cycles when rsp_ready is tied high.
// - alu_a/b/op keep their last value outside EXEC and are reset to 0.
// - Illegal request: rsp_result=0, rsp_branch=0, rsp_taken=0, rsp_illegal=1; the ALU is not exercised.
// - req_valid while busy is ignored (req_ready=0); the upstream stage must hold the request.
// - rst in any state: IDLE next cycle, in-flight transaction dropped, no response emitted.
// - Arithmetic is entirely in the ALU; this block performs no add/compare on data.
// STRUCTURE
// - Shared package: ALU op localparams, RV opcode/funct3 localparams, FSM state encoding.
// - One sub-module alu_op_decode (combinational: opcode/funct3/funct7 -> op, use_imm, is_branch, br_kind, illegal).
// - FSM plus capture registers live in this module; the bench instantiates ALU_64bit as the responder.
// TESTING
// - ADD, a=5, b=7, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_result=12, rsp_taken=0.
// - SUB, a=3, b=5 -> rsp_result=64'hFFFF_FFFF_FFFF_FFFE; ADDI, rs1=10, imm=-1 -> rsp_result=9.
// - Branches, each with rsp_branch=1 and rsp_tag echoed:
//   - BEQ rs1=rs2=9 -> taken=1.
//   - BNE 9,9 -> taken=0.
//   - BLT -1,1 -> taken=1.
//   - BGE -1,1 -> taken=0.
// - SLLI, rs1=1, imm=4 -> alu_op=1000, rsp_result=16; opcode 1110011 -> rsp_illegal=1, rsp_result=0 at N+1.
// - rsp_ready held low 5 cycles -> rsp_* stable, req_ready=0, second req_valid not accepted until the handshake completes.
// - rst asserted during EXEC -> next cycle IDLE, req_ready=1, rsp_valid stays 0; random back-to-back ops match reference-model decode.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALU op codes, RV64 opcode and
// funct fields, FSM state encoding and branch-kind classification.
package alu_issue_ctrl_pkg;

  // ALU op codes understood by the 64-bit ALU
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_BLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;

  // RV64 major opcodes handled by this block
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_DWORD   = 3'b011;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LT = 2'b10,
    BR_GE = 2'b11
  } br_kind_t;

  // The ALU's BLT op yields 0 when a<b, so BLT and BEQ are both taken on zero.
  function automatic logic br_taken(input br_kind_t kind, input logic zero);
    logic t;
    case (kind)
      BR_EQ, BR_LT: t = zero;
      BR_NE, BR_GE: t = ~zero;
      default:      t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_op_decode.sv
// Combinational decode of RV64 opcode/funct3/funct7 into ALU op, operand-b
// select, branch classification and illegal flag.
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] op,
  output logic       use_imm,
  output logic       is_branch,
  output br_kind_t   br_kind,
  output logic       illegal
);

  // Decode table; anything not matched stays illegal
  always_comb begin
    op        = ALU_ADD;
    use_imm   = 1'b0;
    is_branch = 1'b0;
    br_kind   = BR_EQ;
    illegal   = 1'b1;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          illegal = 1'b0;
          case (funct3)
            F3_ADD_SUB: op = ALU_ADD;
            F3_AND:     op = ALU_AND;
            F3_OR:      op = ALU_OR;
            F3_SLL:     op = ALU_SLL;
            default:    illegal = 1'b1;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          op      = ALU_SUB;
          illegal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        if (funct3 == F3_ADD_SUB) begin
          op      = ALU_ADD;
          illegal = 1'b0;
        end else if (funct3 == F3_SLL && funct7[6:1] == 6'b000000) begin
          // funct7[0] is shamt[5] in RV64, so only the upper six bits qualify
          op      = ALU_SLL;
          illegal = 1'b0;
        end
      end
      OPC_LOAD, OPC_STORE: begin
        use_imm = 1'b1;
        op      = ALU_ADD;
        illegal = (funct3 != F3_DWORD);
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        illegal   = 1'b0;
        case (funct3)
          F3_BEQ: begin op = ALU_SUB; br_kind = BR_EQ; end
          F3_BNE: begin op = ALU_SUB; br_kind = BR_NE; end
          F3_BLT: begin op = ALU_BLT; br_kind = BR_LT; end
          F3_BGE: begin op = ALU_BLT; br_kind = BR_GE; end
          default: begin is_branch = 1'b0; illegal = 1'b1; end
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts a decoded instruction, drives registered operands
// into an external combinational ALU, captures its result and returns a tagged
// response with branch resolution. One transaction in flight at a time.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        req_opcode,
  input  logic [2:0]        req_funct3,
  input  logic [6:0]        req_funct7,
  input  logic [DATA_W-1:0] req_rs1,
  input  logic [DATA_W-1:0] req_rs2,
  input  logic [DATA_W-1:0] req_imm,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_branch,
  output logic              rsp_taken,
  output logic              rsp_illegal,
  output logic [TAG_W-1:0]  rsp_tag
);

  state_t     state;
  logic       is_branch_q;
  br_kind_t   br_kind_q;

  logic [3:0] dec_op;
  logic       dec_use_imm;
  logic       dec_is_branch;
  br_kind_t   dec_br_kind;
  logic       dec_illegal;

  alu_op_decode u_decode (
    .opcode    (req_opcode),
    .funct3    (req_funct3),
    .funct7    (req_funct7),
    .op        (dec_op),
    .use_imm   (dec_use_imm),
    .is_branch (dec_is_branch),
    .br_kind   (dec_br_kind),
    .illegal   (dec_illegal)
  );

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  // FSM, operand issue registers and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      is_branch_q <= 1'b0;
      br_kind_q   <= BR_EQ;
      rsp_result  <= '0;
      rsp_branch  <= 1'b0;
      rsp_taken   <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_tag     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            rsp_tag <= req_tag;
            if (dec_illegal) begin
              // Illegal requests bypass EXEC and leave the ALU operands untouched
              rsp_result  <= '0;
              rsp_branch  <= 1'b0;
              rsp_taken   <= 1'b0;
              rsp_illegal <= 1'b1;
              state       <= ST_RESP;
            end else begin
              alu_a       <= req_rs1;
              alu_b       <= dec_use_imm ? req_imm : req_rs2;
              alu_op      <= dec_op;
              is_branch_q <= dec_is_branch;
              br_kind_q   <= dec_br_kind;
              rsp_illegal <= 1'b0;
              state       <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          rsp_result <= alu_result;
          rsp_branch <= is_branch_q;
          rsp_taken  <= is_branch_q & br_taken(br_kind_q, alu_zero);
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural 64-bit ALU responder.
module tb_alu_issue_ctrl;

  localparam int DATA_W = 64;
  localparam int TAG_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [6:0]        req_opcode;
  logic [2:0]        req_funct3;
  logic [6:0]        req_funct7;
  logic [DATA_W-1:0] req_rs1, req_rs2, req_imm;
  logic [TAG_W-1:0]  req_tag;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_branch, rsp_taken, rsp_illegal;
  logic [TAG_W-1:0]  rsp_tag;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_branch(rsp_branch), .rsp_taken(rsp_taken),
    .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag)
  );

  // ALU_64bit responder
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 64'd0 : 64'd1;
      4'b1000: alu_result = alu_a << alu_b[5:0];
      4'b1100: alu_result = ~(alu_a | alu_b);
      4'b1101: alu_result = ~(alu_a & alu_b);
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  typedef struct {
    logic [63:0] result;
    logic        branch;
    logic        taken;
    logic        illegal;
    logic [3:0]  tag;
    logic [3:0]  op;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  bit          rnd_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: instruction semantics straight from the RV64 rules
  function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                                 input logic [3:0] tag);
    exp_t e;
    e.result = '0; e.branch = 0; e.taken = 0; e.illegal = 0; e.tag = tag; e.op = '0; e.acc = 0;
    if (opc == 7'b0110011 && f7 == 7'd0 && f3 == 3'd0) begin e.result = rs1 + rs2; e.op = 4'b0010; end
    else if (opc == 7'b0110011 && f7 == 7'd0 && f3 == 3'd7) begin e.result = rs1 & rs2; e.op = 4'b0000; end
    else if (opc == 7'b0110011 && f7 == 7'd0 && f3 == 3'd6) begin e.result = rs1 | rs2; e.op = 4'b0001; end
    else if (opc == 7'b0110011 && f7 == 7'd0 && f3 == 3'd1) begin e.result = rs1 << rs2[5:0]; e.op = 4'b1000; end
    else if (opc == 7'b0110011 && f7 == 7'h20 && f3 == 3'd0) begin e.result = rs1 - rs2; e.op = 4'b0110; end
    else if (opc == 7'b0010011 && f3 == 3'd0) begin e.result = rs1 + imm; e.op = 4'b0010; end
    else if (opc == 7'b0010011 && f3 == 3'd1 && f7 <= 7'd1) begin e.result = rs1 << imm[5:0]; e.op = 4'b1000; end
    else if ((opc == 7'b0000011 || opc == 7'b0100011) && f3 == 3'd3) begin e.result = rs1 + imm; e.op = 4'b0010; end
    else if (opc == 7'b1100011 && (f3 == 3'd0 || f3 == 3'd1)) begin
      e.branch = 1; e.op = 4'b0110; e.result = rs1 - rs2;
      e.taken = (f3 == 3'd0) ? (rs1 == rs2) : (rs1 != rs2);
    end
    else if (opc == 7'b1100011 && (f3 == 3'd4 || f3 == 3'd5)) begin
      e.branch = 1; e.op = 4'b0111;
      e.result = ($signed(rs1) < $signed(rs2)) ? 64'd0 : 64'd1;
      e.taken = (f3 == 3'd4) ? ($signed(rs1) < $signed(rs2)) : ($signed(rs1) >= $signed(rs2));
    end
    else e.illegal = 1;
    return e;
  endfunction

  // Driver: present a request at posedge+1 and hold it until accepted
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                       input logic [3:0] tag, output int unsigned acc);
    exp_t e;
    bit ok;
    ok = 0;
    acc = 0;
    req_opcode = opc; req_funct3 = f3; req_funct7 = f7;
    req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_tag = tag;
    req_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (ok) begin
      acc = cyc;
      e = model(opc, f3, f7, rs1, rs2, imm, tag);
      e.acc = acc;
      sb.push_back(e);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: req_ready never seen for tag %0d", tag);
    end
  endtask

  // Monitor: pops the scoreboard on each new response and checks stability while stalled
  initial begin : monitor
    bit          active;
    exp_t        e;
    logic [72:0] snap;
    active = 0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
        continue;
      end
      if (rsp_valid) begin
        chk("req_ready_busy", {63'd0, req_ready}, 64'd0);
        if (!active) begin
          active = 1;
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: got tag %0d expected no response", rsp_tag);
          end else begin
            e = sb.pop_front();
            chk("rsp_result", rsp_result, e.result);
            chk("rsp_branch", {63'd0, rsp_branch}, {63'd0, e.branch});
            chk("rsp_taken", {63'd0, rsp_taken}, {63'd0, e.taken});
            chk("rsp_illegal", {63'd0, rsp_illegal}, {63'd0, e.illegal});
            chk("rsp_tag", {60'd0, rsp_tag}, {60'd0, e.tag});
            chk("latency", 64'(cyc - e.acc), e.illegal ? 64'd0 : 64'd1);
            if (!e.illegal) chk("alu_op", {60'd0, alu_op}, {60'd0, e.op});
          end
          snap = {rsp_result, rsp_branch, rsp_taken, rsp_illegal, rsp_tag, 2'b00};
        end else begin
          chk("rsp_stable", {55'd0, snap[8:0]} ^ snap[72:9] ^ 64'd0,
              {55'd0, rsp_branch, rsp_taken, rsp_illegal, rsp_tag, 2'b00} ^ rsp_result);
        end
        if (rsp_ready) active = 0;
      end
    end
  end

  // Random consumer back-pressure for the random phase
  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : main
    int unsigned acc, acc_b, rel;
    logic [63:0] r1, r2, im;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [2:0]  rf3 [4];
    logic [2:0]  bf3 [4];
    int          w;
    rf3 = '{3'd0, 3'd7, 3'd6, 3'd1};
    bf3 = '{3'd0, 3'd1, 3'd4, 3'd5};

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_opcode = '0; req_funct3 = '0; req_funct7 = '0;
    req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_rsp_fields", {rsp_result[62:0] | 63'(rsp_tag), rsp_branch | rsp_taken | rsp_illegal}, 64'd0);
    chk("reset_alu_a", alu_a, 64'd0);
    chk("reset_alu_b", alu_b, 64'd0);
    chk("reset_alu_op", {60'd0, alu_op}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed operations
    issue(7'b0110011, 3'd0, 7'h00, 64'd5, 64'd7, 64'd0, 4'd1, acc);
    issue(7'b0110011, 3'd0, 7'h20, 64'd3, 64'd5, 64'd0, 4'd2, acc);
    issue(7'b0010011, 3'd0, 7'h7f, 64'd10, 64'd0, '1, 4'd3, acc);
    issue(7'b1100011, 3'd0, 7'h00, 64'd9, 64'd9, 64'd0, 4'd4, acc);
    issue(7'b1100011, 3'd1, 7'h00, 64'd9, 64'd9, 64'd0, 4'd5, acc);
    issue(7'b1100011, 3'd4, 7'h00, '1, 64'd1, 64'd0, 4'd6, acc);
    issue(7'b1100011, 3'd5, 7'h00, '1, 64'd1, 64'd0, 4'd7, acc);
    issue(7'b0010011, 3'd1, 7'h00, 64'd1, 64'd0, 64'd4, 4'd8, acc);
    issue(7'b1110011, 3'd0, 7'h00, 64'd1, 64'd2, 64'd3, 4'd9, acc);

    // Consumer stall: second request must wait for the handshake
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(7'b0110011, 3'd7, 7'h00, 64'hF0F0, 64'h0FF0, 64'd0, 4'd10, acc);
    rel = 0;
    acc_b = 0;
    fork
      issue(7'b0110011, 3'd6, 7'h00, 64'hF000, 64'h000F, 64'd0, 4'd11, acc_b);
      begin
        repeat (6) @(posedge clk);
        #1;
        rel = cyc;
        rsp_ready = 1'b1;
      end
    join
    chk("accept_after_handshake", 64'(acc_b), 64'(rel + 2));

    // Reset during EXEC drops the transaction
    repeat (3) @(posedge clk); #1;
    issue(7'b0110011, 3'd0, 7'h00, 64'd100, 64'd200, 64'd0, 4'd12, acc);
    rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_req_ready", {63'd0, req_ready}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("rst_exec_no_rsp", {63'd0, rsp_valid}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Random back-to-back traffic with random back-pressure
    rnd_ready = 1;
    for (int n = 0; n < 300; n++) begin
      r1 = {$urandom, $urandom};
      r2 = ($urandom_range(0, 3) == 0) ? r1 : {$urandom, $urandom};
      im = 64'($signed($urandom_range(0, 4095)) - 2048);
      f7 = 7'h00;
      f3 = 3'd0;
      w = $urandom_range(0, 9);
      case (w)
        0: begin opc = 7'b0110011; f3 = rf3[$urandom_range(0, 3)]; end
        1: begin opc = 7'b0110011; f7 = 7'h20; end
        2: begin opc = 7'b0010011; f7 = 7'($urandom); end
        3: begin opc = 7'b0010011; f3 = 3'd1; f7 = 7'($urandom_range(0, 1)); im = 64'($urandom_range(0, 63)); end
        4: begin opc = 7'b0000011; f3 = 3'd3; end
        5: begin opc = 7'b0100011; f3 = 3'd3; end
        6, 7: begin opc = 7'b1100011; f3 = bf3[$urandom_range(0, 3)]; end
        8: begin opc = 7'($urandom); f3 = 3'($urandom); f7 = 7'($urandom); end
        default: begin
          case ($urandom_range(0, 4))
            0: opc = 7'b0110011;
            1: opc = 7'b0010011;
            2: opc = 7'b0000011;
            3: opc = 7'b0100011;
            default: opc = 7'b1100011;
          endcase
          f3 = 3'($urandom);
          f7 = ($urandom_range(0, 1) == 0) ? 7'($urandom) : 7'h00;
        end
      endcase
      issue(opc, f3, f7, r1, r2, im, 4'($urandom), acc);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    // Drain
    rnd_ready = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
